// File: rtl/reg_dump_reader_pkg.sv
// Shared definitions for the register dump reader: FSM encoding, record layout and byte extraction.
// Each record is one index byte followed by the 32-bit register value, most significant byte first.
package reg_dump_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2
  } state_t;

  localparam int         RECORD_BYTES  = 5;
  localparam logic [2:0] IDX_BYTE      = 3'd0;
  localparam logic [2:0] DATA_MSB_BYTE = 3'd1;
  localparam logic [2:0] DATA_LSB_BYTE = 3'd4;

  // Byte n of the record (1..4) is data byte (4-n) counted from the LSB.
  function automatic logic [7:0] data_byte(input logic [31:0] d, input logic [2:0] n);
    logic [2:0]  w_rev;
    logic [31:0] w_shift;
    w_rev   = DATA_LSB_BYTE - n;
    w_shift = d >> {w_rev, 3'b000};
    return w_shift[7:0];
  endfunction

endpackage

// File: rtl/reg_dump_byte_sel.sv
// Combinational record byte mux: picks the index byte or one shadow data byte by byte_cnt.
// Zero latency; no flow control of its own.
module reg_dump_byte_sel
  import reg_dump_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = 5
) (
  input  logic [ADDR_WIDTH-1:0] i_idx,
  input  logic [31:0]           i_shadow,
  input  logic [2:0]            i_byte_cnt,
  output logic [7:0]            o_byte
);

  always_comb begin
    o_byte = 8'h00;
    if (i_byte_cnt == IDX_BYTE) begin
      o_byte = 8'(i_idx);
    end else if (i_byte_cnt >= DATA_MSB_BYTE && i_byte_cnt <= DATA_LSB_BYTE) begin
      o_byte = data_byte(i_shadow, i_byte_cnt);
    end
  end

endmodule

// File: rtl/reg_dump_reader.sv
// Walks all registers through a spare register-file read port and streams 5-byte records.
// One FETCH cycle plus five SEND cycles per register; out_ready low stalls SEND indefinitely.
module reg_dump_reader
  import reg_dump_reader_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM        = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_abort,
  output logic [ADDR_WIDTH-1:0] o_rf_addr,
  input  logic [WIDTH-1:0]      i_rf_data,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [7:0]            o_out_data,
  output logic                  o_out_last,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX      = ADDR_WIDTH'(NUM - 1);
  localparam logic [2:0]            PRE_LAST_BYTE = DATA_LSB_BYTE - 3'd1;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [2:0]            r_byte_cnt;
  logic [WIDTH-1:0]      r_shadow;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_hs;
  logic                  w_last_byte;
  logic [7:0]            w_byte;

  assign w_hs        = r_out_valid & i_out_ready;
  assign w_last_byte = (r_byte_cnt == DATA_LSB_BYTE);

  reg_dump_byte_sel #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_byte_sel (
    .i_idx      (r_idx),
    .i_shadow   (r_shadow),
    .i_byte_cnt (r_byte_cnt),
    .o_byte     (w_byte)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_byte_cnt  <= IDX_BYTE;
      r_shadow    <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // Abort wins over start and over any handshake in the same cycle.
      if (i_abort) begin
        r_state     <= ST_IDLE;
        r_idx       <= '0;
        r_byte_cnt  <= IDX_BYTE;
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
        r_busy      <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (i_start) begin
              r_state <= ST_FETCH;
              r_idx   <= '0;
              r_busy  <= 1'b1;
            end
          end
          ST_FETCH: begin
            r_shadow    <= i_rf_data;
            r_byte_cnt  <= IDX_BYTE;
            r_out_valid <= 1'b1;
            r_out_last  <= 1'b0;
            r_state     <= ST_SEND;
          end
          ST_SEND: begin
            if (w_hs) begin
              if (!w_last_byte) begin
                r_byte_cnt <= r_byte_cnt + 3'd1;
                r_out_last <= (r_idx == LAST_IDX) && (r_byte_cnt == PRE_LAST_BYTE);
              end else if (r_idx != LAST_IDX) begin
                r_idx       <= r_idx + 1'b1;
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
                r_state     <= ST_FETCH;
              end else begin
                r_idx       <= '0;
                r_byte_cnt  <= IDX_BYTE;
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
                r_busy      <= 1'b0;
                r_done      <= 1'b1;
                r_state     <= ST_IDLE;
              end
            end
          end
          default: begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_byte_cnt  <= IDX_BYTE;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_rf_addr   = r_idx;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_valid ? w_byte : 8'h00;
  assign o_out_last  = r_out_last;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader: drives a register-file model and checks the byte stream.
module tb_reg_dump_reader;

  logic        clk = 1'b0;
  logic        reset, start, abort, out_ready;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        out_valid, out_last, busy, done;
  logic [7:0]  out_data;

  logic [31:0] rf     [32];
  logic [31:0] exp_rf [32];
  logic [7:0]  byte_q [$];
  bit          last_q [$];

  int n_cmp = 0, n_fail = 0;
  int cyc = 0, done_cnt = 0, done_cyc = 0, stall_bad = 0, t0 = 0, d0 = 0;
  bit toggle_rdy = 1'b0;
  bit ok;

  always #5 clk = ~clk;

  assign rf_data = rf[rf_addr];

  reg_dump_reader #(.WIDTH(32), .ADDR_WIDTH(5), .NUM(32)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_start     (start),
    .i_abort     (abort),
    .o_rf_addr   (rf_addr),
    .i_rf_data   (rf_data),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (out_data),
    .o_out_last  (out_last),
    .o_busy      (busy),
    .o_done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Logs the handshake the coming edge will see, advances one edge, then checks stall stability.
  task automatic tick();
    logic       hold;
    logic [7:0] held_d;
    logic       held_l;
    hold   = out_valid && !out_ready && !abort && !reset;
    held_d = out_data;
    held_l = out_last;
    if (out_valid && out_ready) begin
      byte_q.push_back(out_data);
      last_q.push_back(out_last);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (hold && (!out_valid || out_data !== held_d || out_last !== held_l)) stall_bad++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (toggle_rdy) out_ready = ~out_ready;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_stream();
    byte_q.delete();
    last_q.delete();
  endtask

  task automatic run_to_done(input int budget, output bit done_ok);
    int d_start;
    d_start = done_cnt;
    for (int i = 0; i < budget && done_cnt == d_start; i++) tick();
    done_ok = (done_cnt != d_start);
  endtask

  task automatic run_to_bytes(input int n, input int budget, output bit reached);
    for (int i = 0; i < budget && byte_q.size() < n; i++) tick();
    reached = (byte_q.size() >= n);
  endtask

  function automatic logic [7:0] exp_byte(input int k);
    int          r, b;
    logic [31:0] s;
    r = k / 5;
    b = k % 5;
    if (b == 0) return 8'(r);
    s = exp_rf[r] >> (8 * (4 - b));
    return s[7:0];
  endfunction

  task automatic check_stream(input string tag);
    int bad, lasts;
    bad   = 0;
    lasts = 0;
    chk({tag, "_len"}, byte_q.size(), 160);
    for (int k = 0; k < byte_q.size(); k++) begin
      if (byte_q[k] !== exp_byte(k)) bad++;
      if (last_q[k]) lasts++;
    end
    chk({tag, "_bad_bytes"}, bad, 0);
    chk({tag, "_last_count"}, lasts, 1);
    if (last_q.size() == 160) chk({tag, "_last_pos"}, 32'(last_q[159]), 1);
  endtask

  task automatic check_record(input string tag, input int r, input logic [39:0] rec);
    if (byte_q.size() >= 5 * r + 5) begin
      for (int b = 0; b < 5; b++)
        chk($sformatf("%s_b%0d", tag, b), byte_q[5 * r + b], rec[8 * (4 - b) +: 8]);
    end else begin
      chk({tag, "_present"}, byte_q.size(), 5 * r + 5);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    rf[28] = 32'h0000_1800;
    rf[29] = 32'h0000_2ffe;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rf_addr", rf_addr, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;
    tick();
    tick();

    // Full dump at register-file reset values, out_ready always high.
    out_ready = 1'b1;
    exp_rf = rf;
    clear_stream();
    pulse_start();
    t0 = cyc;
    chk("t1_fetch_busy", busy, 1);
    chk("t1_fetch_valid", out_valid, 0);
    chk("t1_fetch_addr", rf_addr, 0);
    tick();
    chk("t1_first_valid", out_valid, 1);
    chk("t1_first_byte", out_data, 8'h00);
    run_to_done(400, ok);
    chk("t1_done_seen", ok, 1);
    chk("t1_done_latency", done_cyc - t0, 192);
    chk("t1_busy_at_done", busy, 0);
    chk("t1_valid_at_done", out_valid, 0);
    tick();
    chk("t1_done_one_cycle", done, 0);
    check_stream("t1");
    check_record("t1_rec28", 28, 40'h1C_00_00_18_00);
    check_record("t1_rec29", 29, 40'h1D_00_00_2F_FE);

    // Backpressure: out_ready toggles every cycle.
    rf[5] = 32'hDEAD_BEEF;
    exp_rf = rf;
    clear_stream();
    stall_bad = 0;
    toggle_rdy = 1'b1;
    pulse_start();
    run_to_done(1000, ok);
    toggle_rdy = 1'b0;
    out_ready = 1'b1;
    chk("t2_done_seen", ok, 1);
    chk("t2_stall_stable", stall_bad, 0);
    check_stream("t2");
    check_record("t2_rec5", 5, 40'h05_DE_AD_BE_EF);

    // Writeback to reg3 while its record is in SEND.
    rf[3] = 32'h1111_1111;
    exp_rf = rf;
    clear_stream();
    pulse_start();
    run_to_bytes(16, 200, ok);
    chk("t3_reached", ok, 1);
    chk("t3_addr", rf_addr, 3);
    chk("t3_in_send", out_valid, 1);
    rf[3] = 32'h2222_2222;
    run_to_done(400, ok);
    chk("t3_done_seen", ok, 1);
    check_stream("t3");
    check_record("t3_rec3", 3, 40'h03_11_11_11_11);

    // Abort during reg10 byte_cnt=2; the byte on the bus that cycle is accepted.
    rf[10] = 32'h00A5_0000;
    exp_rf = rf;
    clear_stream();
    pulse_start();
    run_to_bytes(52, 400, ok);
    chk("t4_reached", ok, 1);
    chk("t4_addr", rf_addr, 10);
    chk("t4_byte2", out_data, 8'hA5);
    d0 = done_cnt;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_valid_drop", out_valid, 0);
    chk("t4_busy_drop", busy, 0);
    chk("t4_addr_zero", rf_addr, 0);
    chk("t4_delivered", byte_q.size(), 53);
    repeat (10) tick();
    chk("t4_no_done", done_cnt - d0, 0);
    clear_stream();
    pulse_start();
    tick();
    chk("t4_restart_addr", rf_addr, 0);
    chk("t4_restart_byte", out_data, 8'h00);
    run_to_done(400, ok);
    chk("t4_done_seen", ok, 1);
    check_stream("t4");

    // Start re-pulsed mid-dump is ignored.
    clear_stream();
    d0 = done_cnt;
    pulse_start();
    t0 = cyc;
    run_to_bytes(35, 400, ok);
    chk("t5_reached", ok, 1);
    chk("t5_addr", rf_addr, 7);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5_still_busy", busy, 1);
    run_to_done(400, ok);
    chk("t5_done_seen", ok, 1);
    chk("t5_done_count", done_cnt - d0, 1);
    chk("t5_done_latency", done_cyc - t0, 192);
    check_stream("t5");

    // Asynchronous reset mid-dump at reg15.
    clear_stream();
    d0 = done_cnt;
    pulse_start();
    run_to_bytes(75, 400, ok);
    chk("t6_reached", ok, 1);
    chk("t6_addr", rf_addr, 15);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_addr", rf_addr, 0);
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_data", out_data, 0);
    chk("t6_rst_last", out_last, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 0);
    #2;
    reset = 1'b0;
    tick();
    chk("t6_no_done", done_cnt - d0, 0);
    clear_stream();
    pulse_start();
    run_to_done(400, ok);
    chk("t6_done_seen", ok, 1);
    check_stream("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
